// File: rtl/leaf_shim_pkg.sv
// rtl/leaf_shim_pkg.sv - shared types and constants for the leaf stream shim
package leaf_shim_pkg;

   // Kernel control sequencing: wait for start, hold ap_start until ready, wait for done
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } fsm_state_t;

   // Entries per skid buffer; two are enough to keep a registered ready at full rate
   localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/leaf_skid_buf.sv
// rtl/leaf_skid_buf.sv - two-entry skid buffer with registered upstream ready
module leaf_skid_buf
   import leaf_shim_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] up_data,
   input  logic         up_valid,
   output logic         up_ready,
   output logic [W-1:0] dn_data,
   output logic         dn_valid,
   input  logic         dn_ready
);

   localparam logic [1:0] FULL = 2'(SKID_DEPTH);

   logic [W-1:0] mem [SKID_DEPTH];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic [1:0]   count_nxt;
   logic         push;
   logic         pop;

   assign push     = up_valid && up_ready;
   assign pop      = dn_valid && dn_ready;
   assign dn_valid = (count != 2'd0);
   assign dn_data  = mem[rd_ptr];

   // Occupancy after this cycle's transfers; push and pop together leave it unchanged
   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + 2'd1;
      end else if (!push && pop) begin
         count_nxt = count - 2'd1;
      end
   end

   // Pointers, occupancy and the registered ready, which looks ahead at the next occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         up_ready <= 1'b0;
      end else begin
         count    <= count_nxt;
         up_ready <= (count_nxt != FULL);
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   // Payload storage; an entry is only written while free, so the head stays stable
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= up_data;
      end
   end

endmodule

// File: rtl/leaf_stream_shim.sv
// rtl/leaf_stream_shim.sv - leaf_interface/HLS kernel stream shim; BEAT_CNT_EN adds beat counters
module leaf_stream_shim
   import leaf_shim_pkg::*;
#(
   parameter int PAYLOAD_BITS = 32,
   parameter int NUM_IN       = 4,
   parameter int NUM_OUT      = 1,
   parameter int CNT_BITS     = 32
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            ap_start_if,
   input  logic [NUM_IN*PAYLOAD_BITS-1:0]  if_in_data,
   input  logic [NUM_IN-1:0]               if_in_vld,
   output logic [NUM_IN-1:0]               if_in_ack,
   output logic [NUM_IN*PAYLOAD_BITS-1:0]  usr_in_tdata,
   output logic [NUM_IN-1:0]               usr_in_tvalid,
   input  logic [NUM_IN-1:0]               usr_in_tready,
   input  logic [NUM_OUT*PAYLOAD_BITS-1:0] usr_out_tdata,
   input  logic [NUM_OUT-1:0]              usr_out_tvalid,
   output logic [NUM_OUT-1:0]              usr_out_tready,
   output logic [NUM_OUT*PAYLOAD_BITS-1:0] if_out_data,
   output logic [NUM_OUT-1:0]              if_out_vld,
   input  logic [NUM_OUT-1:0]              if_out_ack,
   output logic                            usr_ap_start,
   input  logic                            usr_ap_ready,
   input  logic                            usr_ap_done,
   output logic                            run_done,
   output logic [CNT_BITS-1:0]             run_cnt
`ifdef BEAT_CNT_EN
   ,
   output logic [NUM_IN*CNT_BITS-1:0]      in_beats,
   output logic [NUM_OUT*CNT_BITS-1:0]     out_beats
`endif
);

   logic [1:0] rst_sync;
   logic       rst_n_int;
   fsm_state_t state;

   assign rst_n_int = rst_sync[1];

   // Reset asserts immediately and releases two clocks after reset_n rises
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
      leaf_skid_buf #(.W(PAYLOAD_BITS)) u_skid (
         .clk      (clk),
         .rst_n    (rst_n_int),
         .up_data  (if_in_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .up_valid (if_in_vld[gi]),
         .up_ready (if_in_ack[gi]),
         .dn_data  (usr_in_tdata[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .dn_valid (usr_in_tvalid[gi]),
         .dn_ready (usr_in_tready[gi])
      );
   end

   for (genvar go = 0; go < NUM_OUT; go++) begin : g_out
      leaf_skid_buf #(.W(PAYLOAD_BITS)) u_skid (
         .clk      (clk),
         .rst_n    (rst_n_int),
         .up_data  (usr_out_tdata[go*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .up_valid (usr_out_tvalid[go]),
         .up_ready (usr_out_tready[go]),
         .dn_data  (if_out_data[go*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .dn_valid (if_out_vld[go]),
         .dn_ready (if_out_ack[go])
      );
   end

   // Kernel control: raise ap_start until ap_ready, then count the run on ap_done
   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state        <= IDLE;
         usr_ap_start <= 1'b0;
         run_done     <= 1'b0;
         run_cnt      <= '0;
      end else begin
         run_done <= 1'b0;
         case (state)
            IDLE: begin
               if (ap_start_if) begin
                  state        <= START;
                  usr_ap_start <= 1'b1;
               end
            end
            START: begin
               if (usr_ap_ready) begin
                  usr_ap_start <= 1'b0;
                  if (usr_ap_done) begin
                     state    <= IDLE;
                     run_done <= 1'b1;
                     run_cnt  <= run_cnt + CNT_BITS'(1);
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (usr_ap_done) begin
                  state    <= IDLE;
                  run_done <= 1'b1;
                  run_cnt  <= run_cnt + CNT_BITS'(1);
               end
            end
            default: begin
               state        <= IDLE;
               usr_ap_start <= 1'b0;
            end
         endcase
      end
   end

`ifdef BEAT_CNT_EN
   for (genvar bi = 0; bi < NUM_IN; bi++) begin : g_in_cnt
      logic [CNT_BITS-1:0] cnt;
      // Beats accepted from leaf_interface on this input channel
      always_ff @(posedge clk or negedge rst_n_int) begin
         if (!rst_n_int) begin
            cnt <= '0;
         end else if (if_in_vld[bi] && if_in_ack[bi]) begin
            cnt <= cnt + CNT_BITS'(1);
         end
      end
      assign in_beats[bi*CNT_BITS +: CNT_BITS] = cnt;
   end

   for (genvar bo = 0; bo < NUM_OUT; bo++) begin : g_out_cnt
      logic [CNT_BITS-1:0] cnt;
      // Beats accepted from the kernel on this output channel
      always_ff @(posedge clk or negedge rst_n_int) begin
         if (!rst_n_int) begin
            cnt <= '0;
         end else if (usr_out_tvalid[bo] && usr_out_tready[bo]) begin
            cnt <= cnt + CNT_BITS'(1);
         end
      end
      assign out_beats[bo*CNT_BITS +: CNT_BITS] = cnt;
   end
`endif

endmodule

// File: tb/tb_leaf_stream_shim.sv
// tb/tb_leaf_stream_shim.sv - scoreboard bench for leaf_stream_shim; BEAT_CNT_EN checks beat counters
module tb_leaf_stream_shim;

   localparam int PB = 32;
   localparam int NI = 4;
   localparam int NO = 2;
   localparam int CB = 32;

   typedef struct {
      logic [PB-1:0] d;
      int            cyc;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              ap_start_if;
   logic [NI*PB-1:0]  if_in_data;
   logic [NI-1:0]     if_in_vld;
   logic [NI-1:0]     if_in_ack;
   logic [NI*PB-1:0]  usr_in_tdata;
   logic [NI-1:0]     usr_in_tvalid;
   logic [NI-1:0]     usr_in_tready;
   logic [NO*PB-1:0]  usr_out_tdata;
   logic [NO-1:0]     usr_out_tvalid;
   logic [NO-1:0]     usr_out_tready;
   logic [NO*PB-1:0]  if_out_data;
   logic [NO-1:0]     if_out_vld;
   logic [NO-1:0]     if_out_ack;
   logic              usr_ap_start;
   logic              usr_ap_ready;
   logic              usr_ap_done;
   logic              run_done;
   logic [CB-1:0]     run_cnt;
`ifdef BEAT_CNT_EN
   logic [NI*CB-1:0]  in_beats;
   logic [NO*CB-1:0]  out_beats;
`endif

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   beat_t q_in  [NI][$];
   beat_t q_out [NO][$];
   logic  [NI-1:0] lat_chk = '0;
   logic  t3_active = 1'b0;
   logic  saw_ack_low = 1'b0;
   beat_t mb;

   leaf_stream_shim #(.PAYLOAD_BITS(PB), .NUM_IN(NI), .NUM_OUT(NO), .CNT_BITS(CB)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ap_start_if    (ap_start_if),
      .if_in_data     (if_in_data),
      .if_in_vld      (if_in_vld),
      .if_in_ack      (if_in_ack),
      .usr_in_tdata   (usr_in_tdata),
      .usr_in_tvalid  (usr_in_tvalid),
      .usr_in_tready  (usr_in_tready),
      .usr_out_tdata  (usr_out_tdata),
      .usr_out_tvalid (usr_out_tvalid),
      .usr_out_tready (usr_out_tready),
      .if_out_data    (if_out_data),
      .if_out_vld     (if_out_vld),
      .if_out_ack     (if_out_ack),
      .usr_ap_start   (usr_ap_start),
      .usr_ap_ready   (usr_ap_ready),
      .usr_ap_done    (usr_ap_done),
      .run_done       (run_done),
      .run_cnt        (run_cnt)
`ifdef BEAT_CNT_EN
      ,
      .in_beats       (in_beats),
      .out_beats      (out_beats)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare whenever a beat leaves the shim on either side
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (usr_in_tvalid[i] && usr_in_tready[i]) begin
            if (q_in[i].size() == 0) begin
               check($sformatf("in_ch%0d_unexpected_beat", i), 64'(usr_in_tdata[i*PB +: PB]), 64'hDEAD);
            end else begin
               mb = q_in[i].pop_front();
               check($sformatf("in_ch%0d_data", i), 64'(usr_in_tdata[i*PB +: PB]), 64'(mb.d));
               if (lat_chk[i]) check($sformatf("in_ch%0d_latency", i), 64'(cyc - mb.cyc), 64'd1);
            end
         end
      end
      for (int o = 0; o < NO; o++) begin
         if (if_out_vld[o] && if_out_ack[o]) begin
            if (q_out[o].size() == 0) begin
               check($sformatf("out_ch%0d_unexpected_beat", o), 64'(if_out_data[o*PB +: PB]), 64'hDEAD);
            end else begin
               mb = q_out[o].pop_front();
               check($sformatf("out_ch%0d_data", o), 64'(if_out_data[o*PB +: PB]), 64'(mb.d));
            end
         end
      end
      if (t3_active && if_in_vld[0] && !if_in_ack[0]) saw_ack_low = 1'b1;
   end

   task automatic send_in(input int ch, input logic [PB-1:0] d);
      beat_t nb;
      logic  ok = 1'b0;
      if_in_data[ch*PB +: PB] = d;
      if_in_vld[ch] = 1'b1;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         if (if_in_ack[ch]) begin
            nb.d = d;
            nb.cyc = cyc;
            q_in[ch].push_back(nb);
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!ok) check($sformatf("in_ch%0d_ack_timeout", ch), 64'd0, 64'd1);
   endtask

   task automatic send_out(input int ch, input logic [PB-1:0] d);
      beat_t nb;
      logic  ok = 1'b0;
      usr_out_tdata[ch*PB +: PB] = d;
      usr_out_tvalid[ch] = 1'b1;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clk);
         if (usr_out_tready[ch]) begin
            nb.d = d;
            nb.cyc = cyc;
            q_out[ch].push_back(nb);
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!ok) check($sformatf("out_ch%0d_ready_timeout", ch), 64'd0, 64'd1);
   endtask

   task automatic wait_drain(input string name);
      int left = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         left = 0;
         for (int i = 0; i < NI; i++) left += q_in[i].size();
         for (int o = 0; o < NO; o++) left += q_out[o].size();
         if (left == 0) break;
      end
      @(posedge clk); #1;
      check(name, 64'(left), 64'd0);
   endtask

   task automatic wait_start(input string name);
      logic seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (usr_ap_start) seen = 1'b1;
      end
      check(name, 64'(seen), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int exp_runs;
      reset_n        = 1'b1;
      ap_start_if    = 1'b0;
      if_in_data     = '0;
      if_in_vld      = '0;
      usr_in_tready  = '0;
      usr_out_tdata  = '0;
      usr_out_tvalid = '0;
      if_out_ack     = '0;
      usr_ap_ready   = 1'b0;
      usr_ap_done    = 1'b0;
      #1 reset_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst_usr_in_tvalid", 64'(usr_in_tvalid), 64'd0);
      check("rst_if_in_ack", 64'(if_in_ack), 64'd0);
      check("rst_usr_out_tready", 64'(usr_out_tready), 64'd0);
      check("rst_if_out_vld", 64'(if_out_vld), 64'd0);
      check("rst_usr_ap_start", 64'(usr_ap_start), 64'd0);
      check("rst_run_done", 64'(run_done), 64'd0);
      check("rst_run_cnt", 64'(run_cnt), 64'd0);
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_if_in_ack", 64'(if_in_ack), 64'hF);
      usr_in_tready = '1;
      if_out_ack    = '1;

      // Channel 2 burst, consumer always ready: in order, one-cycle latency, no gaps
      lat_chk[2] = 1'b1;
      for (int i = 1; i <= 8; i++) send_in(2, PB'(i));
      if_in_vld[2] = 1'b0;
      wait_drain("t2_drain");
      lat_chk[2] = 1'b0;

      // Channel 0 with a consumer that accepts every other cycle
      t3_active = 1'b1;
      fork
         begin
            for (int k = 0; k < 30; k++) begin
               usr_in_tready[0] = (k % 2 == 0);
               @(posedge clk); #1;
            end
            usr_in_tready[0] = 1'b1;
         end
         begin
            for (int i = 0; i < 8; i++) send_in(0, 32'h300 + PB'(i));
            if_in_vld[0] = 1'b0;
         end
      join
      t3_active = 1'b0;
      wait_drain("t3_drain");
      check("t3_ack_dropped_when_full", 64'(saw_ack_low), 64'd1);

      // Single run: ready on the third cycle of ap_start, done ten cycles later
      ap_start_if = 1'b1;
      wait_start("t4_start_seen");
      @(negedge clk);
      check("t4_ap_start_cycle2", 64'(usr_ap_start), 64'd1);
      @(negedge clk);
      check("t4_ap_start_cycle3", 64'(usr_ap_start), 64'd1);
      usr_ap_ready = 1'b1;
      ap_start_if  = 1'b0;
      @(posedge clk); #1;
      usr_ap_ready = 1'b0;
      @(negedge clk);
      check("t4_ap_start_dropped", 64'(usr_ap_start), 64'd0);
      repeat (9) @(negedge clk);
      check("t4_no_done_yet", 64'(run_done), 64'd0);
      usr_ap_done = 1'b1;
      @(posedge clk); #1;
      usr_ap_done = 1'b0;
      @(negedge clk);
      check("t4_run_done_pulse", 64'(run_done), 64'd1);
      check("t4_run_cnt", 64'(run_cnt), 64'd1);
      @(negedge clk);
      check("t4_run_done_single", 64'(run_done), 64'd0);
      check("t4_idle_no_start", 64'(usr_ap_start), 64'd0);
      exp_runs = 1;
      @(posedge clk); #1;

      // Back-to-back runs with ready and done together, start held high
      ap_start_if = 1'b1;
      for (int r = 0; r < 3; r++) begin
         wait_start($sformatf("t5_start_seen_%0d", r));
         usr_ap_ready = 1'b1;
         usr_ap_done  = 1'b1;
         @(posedge clk); #1;
         usr_ap_ready = 1'b0;
         usr_ap_done  = 1'b0;
         if (r == 2) ap_start_if = 1'b0;
         exp_runs++;
         @(negedge clk);
         check($sformatf("t5_run_done_%0d", r), 64'(run_done), 64'd1);
         check($sformatf("t5_run_cnt_%0d", r), 64'(run_cnt), 64'(exp_runs));
      end
      @(negedge clk);
      check("t5_idle_after", 64'(usr_ap_start), 64'd0);
      @(posedge clk); #1;

      // Reset with two beats parked in channel 1
      usr_in_tready[1] = 1'b0;
      send_in(1, 32'hAA1);
      send_in(1, 32'hAA2);
      if_in_vld[1] = 1'b0;
      check("t1_buffered_valid", 64'(usr_in_tvalid[1]), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t1_rst_tvalid", 64'(usr_in_tvalid), 64'd0);
      check("t1_rst_if_out_vld", 64'(if_out_vld), 64'd0);
      check("t1_rst_run_cnt", 64'(run_cnt), 64'd0);
      check("t1_rst_ack", 64'(if_in_ack), 64'd0);
      q_in[1].delete();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      usr_in_tready[1] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("t1_tvalid_after_reset", 64'(usr_in_tvalid), 64'd0);

      // Five beats on input channel 1, three on output channel 0
      for (int i = 0; i < 5; i++) send_in(1, 32'h1100 + PB'(i));
      if_in_vld[1] = 1'b0;
      for (int i = 0; i < 3; i++) send_out(0, 32'hA0 + PB'(i));
      usr_out_tvalid[0] = 1'b0;
      wait_drain("t6_drain");
`ifdef BEAT_CNT_EN
      for (int i = 0; i < NI; i++)
         check($sformatf("t6_in_beats_%0d", i), 64'(in_beats[i*CB +: CB]), (i == 1) ? 64'd5 : 64'd0);
      for (int o = 0; o < NO; o++)
         check($sformatf("t6_out_beats_%0d", o), 64'(out_beats[o*CB +: CB]), (o == 0) ? 64'd3 : 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
